// File: rtl/mem_if.sv
// -----------------------------------------------------------------------------
// mem_if -- memory interface between the microinstruction datapath and a
// request/acknowledge memory port.
//
// A read (MC = 10) or write (MC = 01) is accepted in IDLE. The block latches
// the address, write data and direction, then holds mem_req high until
// mem_ack is sampled. A one-cycle Mvalid pulse follows each transaction.
// Read data is captured into Mdata and held until the next read completes.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a wait counter bounds the REQ state to TIMEOUT cycles. On
//   expiry the block pulses Mvalid with err set and abandons the access. err
//   stays set until reset or until the next command is accepted.
//   When undefined, REQ waits for mem_ack indefinitely and the err port is
//   absent.
//
// Parameters
//   DW      data width of Mdata / WRdata / memory data
//   AW      address width
//   TIMEOUT maximum REQ cycles without mem_ack (MEM_TIMEOUT_EN only)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   MC[1:0]    command: bit0 = MW (write), bit1 = MR (read); 11 is a no-op
//   addr       access address, sampled when a command is accepted
//   WRdata     write data, sampled when a command is accepted
//   Mdata      read data returned to the register bank
//   Mvalid     one-cycle completion pulse
//   busy       transaction in progress (REQ, DONE, ERR)
//   err        timeout flag (MEM_TIMEOUT_EN only)
//   mem_req    memory request, high throughout REQ
//   mem_we     memory write enable (latched direction)
//   mem_addr   memory address (latched)
//   mem_wdata  memory write data (latched)
//   mem_ack    memory acknowledge, honoured only in REQ
//   mem_rdata  memory read data, captured when mem_ack completes a read
// -----------------------------------------------------------------------------
module mem_if #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    MC,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] WRdata,
    output logic [DW-1:0] Mdata,
    output logic          Mvalid,
    output logic          busy,
`ifdef MEM_TIMEOUT_EN
    output logic          err,
`endif
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    // Command encodings on MC.
    localparam logic [1:0] MC_WRITE = 2'b01;
    localparam logic [1:0] MC_READ  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
`ifdef MEM_TIMEOUT_EN
        , S_ERR
`endif
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   mdata_q;
    logic            mvalid_q;
    logic            busy_q;
    logic            req_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    logic            cmd_valid;

    // Only the two single-bit commands start a transaction; 00 and 11 are no-ops.
    assign cmd_valid = (MC == MC_WRITE) || (MC == MC_READ);

`ifdef MEM_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1: the REQ edge that would bring it
    // to TIMEOUT is the one that expires the access.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic             wait_expired;

    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // Without the timeout option the REQ state has no bound; TIMEOUT is kept
    // so both builds share one parameter list.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; mixing in = would make results depend on the
    // statement order inside the block.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, including the
        // data-path latches, so all outputs read zero in the cycle after reset.
        if (rst) begin
            state_q    <= S_IDLE;
            mdata_q    <= '0;
            mvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Mvalid is a pulse; it is only re-asserted on completing edges.
            mvalid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= addr;
                        wdata_q    <= WRdata;
                        we_q       <= MC[0];
                        req_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_q <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end

                S_REQ: begin
                    // mem_ack is checked first so an acknowledge on the last
                    // allowed cycle still completes the access normally.
                    if (mem_ack) begin
                        if (!we_q) begin
                            mdata_q <= mem_rdata;
                        end
                        req_q    <= 1'b0;
                        mvalid_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_expired) begin
                        req_q    <= 1'b0;
                        mvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= S_ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

`ifdef MEM_TIMEOUT_EN
                S_ERR: begin
                    // err is deliberately left set; it clears on the next
                    // accepted command or on reset.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`endif

                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping.
    // -------------------------------------------------------------------------
    assign Mdata     = mdata_q;
    assign Mvalid    = mvalid_q;
    assign busy      = busy_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_if.sv
// -----------------------------------------------------------------------------
// tb_mem_if -- self-checking bench for mem_if.
//
// The bench plays the memory: it answers each request after a chosen number
// of cycles. Expected values come from the transaction-level rules: the
// latched command fields, the latency from command to Mvalid, and the last
// read data (exp_mdata). Inputs that must be ignored (MC outside IDLE,
// mem_ack outside REQ, addr/WRdata after acceptance) are scrambled with
// $urandom while the checks expect no effect.
//
// Timeout behaviour is exercised when MEM_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_if;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    MC;
    logic [AW-1:0] addr;
    logic [DW-1:0] WRdata;
    logic [DW-1:0] Mdata;
    logic          Mvalid;
    logic          busy;
`ifdef MEM_TIMEOUT_EN
    logic          err;
`endif
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state: the last value a completed read returned.
    logic [DW-1:0] exp_mdata = '0;

    mem_if #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MC        (MC),
        .addr      (addr),
        .WRdata    (WRdata),
        .Mdata     (Mdata),
        .Mvalid    (Mvalid),
        .busy      (busy),
`ifdef MEM_TIMEOUT_EN
        .err       (err),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_mvalid"},  Mvalid,  1'b0);
        check({tag, "_mdata"},   Mdata,   exp_mdata);
    endtask

    // One full transaction issued from IDLE; mem_ack is sampled at edge
    // 'delay' (delay >= 1) counting the command edge as edge 0.
    task automatic run_txn(input logic [1:0] mc, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int delay,
                           input logic [DW-1:0] rd);
        logic is_write;
        is_write  = mc[0];
        MC        = mc;
        addr      = a;
        WRdata    = wd;
        mem_ack   = 1'($urandom_range(0, 1));   // sampled in IDLE: ignored
        mem_rdata = DW'($urandom);
        tick();
        for (int k = 1; k <= delay; k++) begin
            check("req_mem_req",   mem_req,   1'b1);
            check("req_busy",      busy,      1'b1);
            check("req_mvalid",    Mvalid,    1'b0);
            check("req_mem_we",    mem_we,    is_write);
            check("req_mem_addr",  mem_addr,  a);
            check("req_mem_wdata", mem_wdata, wd);
`ifdef MEM_TIMEOUT_EN
            check("req_err",       err,       1'b0);
`endif
            MC        = 2'($urandom_range(1, 3));
            addr      = AW'($urandom);
            WRdata    = DW'($urandom);
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rd : DW'($urandom);
            tick();
        end
        if (!is_write) exp_mdata = rd;
        check("done_mvalid",  Mvalid,  1'b1);
        check("done_mem_req", mem_req, 1'b0);
        check("done_busy",    busy,    1'b1);
        check("done_mdata",   Mdata,   exp_mdata);
        check("done_mem_we",  mem_we,  is_write);
`ifdef MEM_TIMEOUT_EN
        check("done_err",     err,     1'b0);
`endif
        MC      = 2'($urandom_range(1, 3));     // ignored in DONE
        mem_ack = 1'($urandom_range(0, 1));     // ignored in DONE
        tick();
        MC      = 2'b00;
        mem_ack = 1'b0;
        check_idle("post");
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rw;
        logic [DW-1:0] rr;
        logic [1:0]    rmc;
        int            rdel;
        int            gap;

        // ---- Reset with competing inputs: reset must win ----
        rst       = 1'b1;
        MC        = 2'b10;
        addr      = 16'h1234;
        WRdata    = 16'h5678;
        mem_ack   = 1'b1;
        mem_rdata = 16'hAAAA;
        tick();
        tick();
        check("rst_mdata",     Mdata,     '0);
        check("rst_mvalid",    Mvalid,    1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  '0);
        check("rst_mem_wdata", mem_wdata, '0);
`ifdef MEM_TIMEOUT_EN
        check("rst_err",       err,       1'b0);
`endif
        rst     = 1'b0;
        MC      = 2'b00;
        mem_ack = 1'b0;
        tick();
        check_idle("after_rst");

        // ---- Directed read: ack after 3 REQ cycles ----
        run_txn(2'b10, 16'h0040, 16'h0000, 3, 16'hBEEF);
        check("read_mdata", Mdata, 16'hBEEF);

        // ---- Directed write: ack in the first REQ cycle, Mdata kept ----
        run_txn(2'b01, 16'h0010, 16'h000F, 1, 16'h1111);
        check("write_mdata_kept", Mdata, 16'hBEEF);

        // ---- MC = 11 in IDLE is a no-op and latches nothing ----
        for (int i = 0; i < 4; i++) begin
            MC      = 2'b11;
            addr    = AW'($urandom);
            WRdata  = DW'($urandom);
            mem_ack = 1'($urandom_range(0, 1));
            tick();
            check_idle("mc11");
            check("mc11_mem_addr",  mem_addr,  16'h0010);
            check("mc11_mem_wdata", mem_wdata, 16'h000F);
        end
        MC      = 2'b00;
        mem_ack = 1'b0;

        // ---- Randomised transactions with idle gaps ----
        for (int n = 0; n < 40; n++) begin
            rmc  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            ra   = AW'($urandom);
            rw   = DW'($urandom);
            rr   = DW'($urandom);
            rdel = $urandom_range(1, 6);
            run_txn(rmc, ra, rw, rdel, rr);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                MC      = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                mem_ack = 1'($urandom_range(0, 1));
                tick();
                check_idle("gap");
            end
            MC      = 2'b00;
            mem_ack = 1'b0;
        end

        // ---- Reset in the second REQ cycle abandons the access ----
        MC      = 2'b10;
        addr    = 16'h00C0;
        WRdata  = 16'h0000;
        mem_ack = 1'b0;
        tick();                 // first REQ cycle
        MC = 2'b00;
        check("rst_req_mem_req1", mem_req, 1'b1);
        tick();                 // second REQ cycle
        check("rst_req_mem_req2", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        exp_mdata = '0;
        check("rstreq_mdata",     Mdata,     '0);
        check("rstreq_mvalid",    Mvalid,    1'b0);
        check("rstreq_busy",      busy,      1'b0);
        check("rstreq_mem_req",   mem_req,   1'b0);
        check("rstreq_mem_we",    mem_we,    1'b0);
        check("rstreq_mem_addr",  mem_addr,  '0);
        check("rstreq_mem_wdata", mem_wdata, '0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("late_ack");
        end
        mem_ack = 1'b0;

        // A fresh read still works after the abandoned one.
        run_txn(2'b10, 16'h0042, 16'h0000, 2, 16'h600D);

`ifdef MEM_TIMEOUT_EN
        // ---- No mem_ack: ERR after TIMEOUT REQ cycles ----
        MC      = 2'b10;
        addr    = 16'h0080;
        mem_ack = 1'b0;
        tick();
        MC = 2'b00;
        for (int k = 1; k < TIMEOUT; k++) begin
            check("to_mem_req", mem_req, 1'b1);
            check("to_mvalid",  Mvalid,  1'b0);
            tick();
        end
        check("to_req_last", mem_req, 1'b1);
        tick();
        check("err_err",     err,     1'b1);
        check("err_mvalid",  Mvalid,  1'b1);
        check("err_mem_req", mem_req, 1'b0);
        check("err_busy",    busy,    1'b1);
        check("err_mdata",   Mdata,   exp_mdata);
        tick();
        check("err_hold",    err,     1'b1);
        check_idle("after_err");
        tick();
        check("err_hold2",   err,     1'b1);

        // Next accepted command clears err; ack on the last allowed cycle wins.
        run_txn(2'b10, 16'h0084, 16'h0000, TIMEOUT, 16'h0ACE);
        check("ack_at_limit_err", err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
